bram_arbiter: RTL and testbench

Two-port arbiter sharing the single-port `bram` between the core's instruction-fetch port and its load/store port. Each requester uses a req/ack handshake. The arbiter grants one transaction at a time with round-robin priority, drives the BRAM control pins from registers, waits for `rd_valid` on reads, and returns read data to the requester that was granted.

---
 rtl/bram_arbiter_if.sv | 41 ++++
 rtl/bram_arbiter.sv | 91 +++++++++
 tb/tb_bram_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_arbiter_if.sv
// Bundle of the fetch port, load/store port and BRAM pins around bram_arbiter.
// slave is the arbiter's view; master is the core/BRAM side.
interface bram_arbiter_if #(
    parameter int AW = 13,
    parameter int W  = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [W-1:0]  i_rdata;
    logic          i_ack;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [W-1:0]  d_wdata;
    logic [3:0]    d_wmask;
    logic [W-1:0]  d_rdata;
    logic          d_ack;

    logic          m_rd_en;
    logic [AW-1:0] m_addr;
    logic [W-1:0]  m_rd_data;
    logic          m_rd_valid;
    logic          m_wr_en;
    logic [W-1:0]  m_wr_data;
    logic [3:0]    m_wr_mask;

    modport slave (
        input  i_req, i_addr, output i_rdata, i_ack,
        input  d_req, d_we, d_addr, d_wdata, d_wmask, output d_rdata, d_ack,
        output m_rd_en, m_addr, input m_rd_data, m_rd_valid,
        output m_wr_en, m_wr_data, m_wr_mask
    );

    modport master (
        output i_req, i_addr, input i_rdata, i_ack,
        output d_req, d_we, d_addr, d_wdata, d_wmask, input d_rdata, d_ack,
        input  m_rd_en, m_addr, output m_rd_data, m_rd_valid,
        input  m_wr_en, m_wr_data, m_wr_mask
    );
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between instruction fetch
// and load/store; one transaction in flight, all BRAM pins registered.
module bram_arbiter #(
    parameter int AW = 13,
    parameter int W  = 32
) (
    input  logic           clk,
    input  logic           rst,
    bram_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] WR   = 2'd3;

    logic [1:0]    state;
    logic          owner_d;   // 1: D port owns the current transaction
    logic          last_d;    // 1: D port won the most recent grant
    logic          sel_d;
    logic          any_req;
    logic [AW-1:0] sel_addr;
    logic [W-1:0]  rd_word;

    // On a tie the port that did not win last time goes next.
    assign any_req  = bus.i_req | bus.d_req;
    assign sel_d    = bus.d_req & (~bus.i_req | ~last_d);
    assign sel_addr = sel_d ? bus.d_addr : bus.i_addr;
    assign rd_word  = bus.m_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            owner_d       <= 1'b0;
            last_d        <= 1'b1;
            bus.i_rdata   <= '0;
            bus.i_ack     <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_ack     <= 1'b0;
            bus.m_rd_en   <= 1'b0;
            bus.m_addr    <= '0;
            bus.m_wr_en   <= 1'b0;
            bus.m_wr_data <= '0;
            bus.m_wr_mask <= '0;
        end else begin
            bus.i_ack <= 1'b0;
            bus.d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.m_addr <= sel_addr;
                        owner_d    <= sel_d;
                        last_d     <= sel_d;
                        if (sel_d && bus.d_we) begin
                            bus.m_wr_en   <= 1'b1;
                            bus.m_wr_data <= bus.d_wdata;
                            bus.m_wr_mask <= bus.d_wmask;
                            state         <= WR;
                        end else begin
                            bus.m_rd_en <= 1'b1;
                            state       <= RD;
                        end
                    end
                end
                RD: begin
                    bus.m_rd_en <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: begin
                    // rd_valid is only honoured here; stray pulses elsewhere are dropped.
                    if (bus.m_rd_valid) begin
                        if (owner_d) begin
                            bus.d_rdata <= rd_word;
                            bus.d_ack   <= 1'b1;
                        end else begin
                            bus.i_rdata <= rd_word;
                            bus.i_ack   <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                WR: begin
                    bus.m_wr_en   <= 1'b0;
                    bus.m_wr_mask <= '0;
                    bus.d_ack     <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: BRAM model with programmable read latency, and a
// transaction-level reference (grant rule + latency arithmetic + shadow memory).
module tb_bram_arbiter;
    localparam int AW    = 13;
    localparam int W     = 32;
    localparam int WORDS = 1 << (AW - 2);

    typedef struct {
        bit          port_d;
        bit          is_rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    int   rd_delay = 0;
    logic spur = 1'b0;

    bram_arbiter_if #(.AW(AW), .W(W)) bus ();

    bram_arbiter #(.AW(AW), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int k);
        if (k == 4) return 32'h12345678;
        if (k == 8) return 32'h0;
        return 32'h9E3779B9 * (k + 1);
    endfunction

    // BRAM byte lanes: mask[3] covers bits [7:0], mask[0] covers bits [31:24].
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (mask[3-b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // ---------------- BRAM model ----------------
    logic [31:0] mem [WORDS];
    bit          mem_wr [WORDS];
    int          cnt;
    logic [AW-3:0] raddr;

    function automatic logic [31:0] mem_rd(input int k);
        return mem_wr[k] ? mem[k] : init_word(k);
    endfunction

    always @(posedge clk) begin
        if (bus.m_wr_en) begin
            mem[bus.m_addr[AW-1:2]]    <= merge(mem_rd(int'(bus.m_addr[AW-1:2])), bus.m_wr_data, bus.m_wr_mask);
            mem_wr[bus.m_addr[AW-1:2]] <= 1'b1;
        end
        if (rst) begin
            cnt            <= 0;
            bus.m_rd_valid <= 1'b0;
            bus.m_rd_data  <= '0;
        end else if (bus.m_rd_en) begin
            raddr <= bus.m_addr[AW-1:2];
            if (rd_delay == 0) begin
                bus.m_rd_valid <= 1'b1;
                bus.m_rd_data  <= mem_rd(int'(bus.m_addr[AW-1:2]));
            end else begin
                bus.m_rd_valid <= 1'b0;
                cnt            <= rd_delay;
            end
        end else if (cnt == 1) begin
            bus.m_rd_valid <= 1'b1;
            bus.m_rd_data  <= mem_rd(int'(raddr));
            cnt            <= 0;
        end else begin
            bus.m_rd_valid <= spur;
            if (cnt > 1) cnt <= cnt - 1;
        end
    end

    // ---------------- reference model + per-cycle checker ----------------
    initial begin
        exp_t        q[$];
        exp_t        e;
        logic [31:0] sh [WORDS];
        bit          sh_wr [WORDS];
        int          cyc = 0;
        int          busy_until = 0;
        bit          m_last = 1'b1;
        bit          pick_d, exp_rd, exp_wr, exp_ia, exp_da;
        logic [AW-1:0] exp_addr;
        logic [31:0] exp_wd;
        logic [3:0]  exp_wm;
        int          wi;
        forever begin
            @(posedge clk);
            cyc++;
            exp_rd = 1'b0;
            exp_wr = 1'b0;
            if (rst) begin
                q.delete();
                busy_until = 0;
                m_last     = 1'b1;
            end else if (cyc >= busy_until && (bus.i_req || bus.d_req)) begin
                pick_d   = bus.d_req && (!bus.i_req || !m_last);
                m_last   = pick_d;
                exp_addr = pick_d ? bus.d_addr : bus.i_addr;
                wi       = int'(exp_addr[AW-1:2]);
                e.port_d = pick_d;
                if (pick_d && bus.d_we) begin
                    exp_wr    = 1'b1;
                    exp_wd    = bus.d_wdata;
                    exp_wm    = bus.d_wmask;
                    sh[wi]    = merge(sh_wr[wi] ? sh[wi] : init_word(wi), exp_wd, exp_wm);
                    sh_wr[wi] = 1'b1;
                    e.is_rd   = 1'b0;
                    e.data    = '0;
                    e.cyc     = cyc + 1;
                    busy_until = cyc + 2;
                end else begin
                    exp_rd    = 1'b1;
                    e.is_rd   = 1'b1;
                    e.data    = sh_wr[wi] ? sh[wi] : init_word(wi);
                    e.cyc     = cyc + 2 + rd_delay;
                    busy_until = cyc + 3 + rd_delay;
                end
                q.push_back(e);
            end
            #1;
            exp_ia = 1'b0;
            exp_da = 1'b0;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                if (e.port_d) exp_da = 1'b1; else exp_ia = 1'b1;
                if (e.is_rd && e.port_d)  chk("d_rdata", bus.d_rdata, e.data);
                if (e.is_rd && !e.port_d) chk("i_rdata", bus.i_rdata, e.data);
            end
            chk("i_ack", 32'(bus.i_ack), 32'(exp_ia));
            chk("d_ack", 32'(bus.d_ack), 32'(exp_da));
            chk("m_rd_en", 32'(bus.m_rd_en), 32'(exp_rd));
            chk("m_wr_en", 32'(bus.m_wr_en), 32'(exp_wr));
            if (exp_rd || exp_wr) chk("m_addr", 32'(bus.m_addr), 32'(exp_addr));
            if (exp_wr) begin
                chk("m_wr_data", bus.m_wr_data, exp_wd);
                chk("m_wr_mask", 32'(bus.m_wr_mask), 32'(exp_wm));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ack(output int which, output int ncyc);
        which = -1;
        ncyc  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            ncyc++;
            if (bus.i_ack) begin which = 0; break; end
            if (bus.d_ack) begin which = 1; break; end
        end
        if (which < 0) chk("ack_timeout", 32'(ncyc), 32'(0));
    endtask

    task automatic new_i();
        bus.i_req  = 1'b1;
        bus.i_addr = AW'($urandom_range(0, 63));
    endtask

    task automatic new_d();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom);
        bus.d_addr  = AW'($urandom_range(0, 63));
        bus.d_wdata = $urandom;
        bus.d_wmask = 4'($urandom);
    endtask

    initial begin
        int which, n, en_cnt, guard;
        rst = 1'b1;
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wmask = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_m_addr", 32'(bus.m_addr), 32'h0);
        chk("rst_i_rdata", bus.i_rdata, 32'h0);

        // single fetch
        bus.i_req = 1; bus.i_addr = 'h010;
        wait_ack(which, n);
        chk("fetch_port", 32'(which), 32'd0);
        chk("fetch_lat", 32'(n), 32'd3);
        chk("fetch_data", bus.i_rdata, 32'h12345678);
        bus.i_req = 0;

        // masked write then D read back
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 'h020; bus.d_wdata = 32'hAABBCCDD; bus.d_wmask = 4'b1000;
        wait_ack(which, n);
        chk("wr_lat", 32'(n), 32'd2);
        bus.d_we = 0;
        wait_ack(which, n);
        chk("rb_port", 32'(which), 32'd1);
        chk("rb_data", bus.d_rdata, 32'h000000DD);
        bus.d_req = 0;

        // contention: last grant was D, so I leads
        @(negedge clk);
        bus.i_req = 1; bus.i_addr = 'h000;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 'h004;
        for (int k = 0; k < 8; k++) begin
            wait_ack(which, n);
            chk("cont_order", 32'(which), 32'(k % 2));
            chk("cont_gap", 32'(n), 32'd3);
        end
        chk("cont_i_data", bus.i_rdata, init_word(0));
        chk("cont_d_data", bus.d_rdata, init_word(1));
        @(negedge clk);
        bus.i_req = 0; bus.d_req = 0;
        repeat (4) @(negedge clk);

        // stalled BRAM
        rd_delay = 5;
        bus.i_req = 1; bus.i_addr = 'h010;
        en_cnt = 0; n = 0; which = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n++;
            if (bus.m_rd_en) en_cnt++;
            if (bus.i_ack) begin which = 0; break; end
        end
        chk("stall_port", 32'(which), 32'd0);
        chk("stall_lat", 32'(n), 32'd8);
        chk("stall_rd_en_pulses", 32'(en_cnt), 32'd1);
        bus.i_req = 0;
        rd_delay = 0;
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("spur_valid_seen", 32'(bus.m_rd_valid), 32'd1);
        @(negedge clk);
        chk("spur_i_ack", 32'(bus.i_ack), 32'd0);
        chk("spur_d_ack", 32'(bus.d_ack), 32'd0);

        // reset during WAIT of a D read
        rd_delay = 4;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 'h004;
        repeat (2) @(negedge clk);
        bus.i_req = 1; bus.i_addr = 'h010;
        #2 rst = 1'b1;
        #1;
        chk("arst_m_addr", 32'(bus.m_addr), 32'h0);
        chk("arst_d_rdata", bus.d_rdata, 32'h0);
        chk("arst_m_rd_en", 32'(bus.m_rd_en), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ack(which, n);
        chk("post_rst_first", 32'(which), 32'd0);
        bus.i_req = 0;
        wait_ack(which, n);
        chk("post_rst_second", 32'(which), 32'd1);
        bus.d_req = 0;
        rd_delay = 0;
        repeat (3) @(negedge clk);

        // randomized bursts
        for (int b = 0; b < 4; b++) begin
            rd_delay = $urandom_range(0, 3);
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                if (!bus.i_req) begin
                    if ($urandom_range(0, 2) == 0) new_i();
                end else if (bus.i_ack) begin
                    if ($urandom_range(0, 1) == 0) new_i(); else bus.i_req = 0;
                end
                if (!bus.d_req) begin
                    if ($urandom_range(0, 2) == 0) new_d();
                end else if (bus.d_ack) begin
                    if ($urandom_range(0, 1) == 0) new_d(); else bus.d_req = 0;
                end
            end
            guard = 0;
            while ((bus.i_req || bus.d_req) && guard < 100) begin
                @(negedge clk);
                guard++;
                if (bus.i_ack) bus.i_req = 0;
                if (bus.d_ack) bus.d_req = 0;
            end
            if (bus.i_req || bus.d_req) chk("drain_timeout", 32'(guard), 32'd0);
            repeat (6) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
